if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_if.sv | 31 +++
 rtl/if_stage.sv | 108 ++++++++++
 tb/tb_if_stage.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : if_stage_if
// Brief    : Instruction-memory request/response bus between the fetch stage
//            (master) and instruction memory (slave).
// Revision : 1.0
// ============================================================================
interface if_stage_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );
endinterface
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Brief    : Instruction fetch stage with one outstanding memory request,
//            branch/jump redirect and cancellation of in-flight fetches.
// Revision : 1.0
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1C000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_en,
    input  logic [31:0]       branch_addr,
    input  logic              jump_en,
    input  logic [31:0]       jump_addr,
    if_stage_if.master        mem,
    output logic              if_valid,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_inst,
    input  logic              id_ready
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic        r_cancel;
    logic        r_if_valid;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_inst;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pc_inc;

    assign w_redirect = jump_en | branch_en;
    assign w_target   = (jump_en ? jump_addr : branch_addr) & 32'hFFFF_FFFC;
    assign w_pc_inc   = r_pc + 32'd4;

    assign mem.inst_req  = (r_state == S_REQ);
    assign mem.inst_addr = r_pc;
    assign if_valid      = r_if_valid;
    assign if_pc         = r_if_pc;
    assign if_inst       = r_if_inst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_cancel   <= 1'b0;
            r_if_valid <= 1'b0;
            r_if_pc    <= 32'd0;
            r_if_inst  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_redirect) r_pc <= w_target;
                    r_state <= S_REQ;
                end
                S_REQ: begin
                    if (w_redirect) r_pc <= w_target;
                    // An accepted request that coincides with a redirect is
                    // already stale; its data must be thrown away on return.
                    if (mem.inst_addr_ok) begin
                        r_state  <= S_WAIT;
                        r_cancel <= w_redirect;
                    end
                end
                S_WAIT: begin
                    if (mem.inst_data_ok) begin
                        if (r_cancel || w_redirect) begin
                            r_cancel <= 1'b0;
                            r_state  <= S_REQ;
                            if (w_redirect) r_pc <= w_target;
                        end else begin
                            r_if_valid <= 1'b1;
                            r_if_pc    <= r_pc;
                            r_if_inst  <= mem.inst_rdata;
                            r_pc       <= w_pc_inc;
                            r_state    <= S_OUT;
                        end
                    end else if (w_redirect) begin
                        r_pc     <= w_target;
                        r_cancel <= 1'b1;
                    end
                end
                S_OUT: begin
                    // A redirect flushes the held instruction even if ID takes it.
                    if (w_redirect) begin
                        r_if_valid <= 1'b0;
                        r_pc       <= w_target;
                        r_state    <= S_REQ;
                    end else if (id_ready) begin
                        r_if_valid <= 1'b0;
                        r_state    <= S_REQ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Brief    : Self-checking bench for if_stage: transaction-level reference
//            model, random memory/redirect/stall stimulus and directed cases.
// Revision : 1.0
// ============================================================================
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h1C000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_en;
    logic [31:0] branch_addr;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        id_ready;

    if_stage_if mem_bus ();

    if_stage #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .branch_en   (branch_en),
        .branch_addr (branch_addr),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .mem         (mem_bus),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .id_ready    (id_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // Reference model: fetch pointer, at most one fetch in flight (possibly
    // killed), and the instruction currently held for ID.
    bit          m_first   = 1'b0;
    bit          m_fly     = 1'b0;
    bit          m_kill    = 1'b0;
    bit          m_valid   = 1'b0;
    logic [31:0] m_pc      = 32'd0;
    logic [31:0] m_fly_addr = 32'd0;
    logic [31:0] m_ifpc    = 32'd0;
    logic [31:0] m_ifinst  = 32'd0;
    bit          chk_en    = 1'b0;

    always @(posedge clk) begin : ref_model
        logic        redir;
        logic [31:0] tgt;
        redir = jump_en | branch_en;
        tgt   = (jump_en ? jump_addr : branch_addr) & 32'hFFFF_FFFC;
        if (rst) begin
            m_first = 1'b1; m_pc = RST_PC; m_fly = 1'b0; m_kill = 1'b0;
            m_valid = 1'b0; m_ifpc = 32'd0; m_ifinst = 32'd0;
        end else if (m_first) begin
            m_first = 1'b0;
            if (redir) m_pc = tgt;
        end else if (m_valid) begin
            if (redir) begin
                m_valid = 1'b0; m_pc = tgt;
            end else if (id_ready) begin
                m_valid = 1'b0;
            end
        end else if (m_fly) begin
            if (mem_bus.inst_data_ok) begin
                m_fly = 1'b0;
                if (m_kill || redir) begin
                    m_kill = 1'b0;
                    if (redir) m_pc = tgt;
                end else begin
                    m_valid  = 1'b1;
                    m_ifpc   = m_fly_addr;
                    m_ifinst = memword(m_fly_addr);
                    m_pc     = m_fly_addr + 32'd4;
                end
            end else if (redir) begin
                m_pc = tgt; m_kill = 1'b1;
            end
        end else begin
            if (mem_bus.inst_addr_ok) begin
                m_fly = 1'b1; m_kill = redir; m_fly_addr = m_pc;
            end
            if (redir) m_pc = tgt;
        end
    end

    always @(negedge clk) begin : compare
        logic exp_req;
        if (chk_en) begin
            exp_req = !m_first && !m_fly && !m_valid;
            check("inst_req", {31'd0, mem_bus.inst_req}, {31'd0, exp_req});
            if (exp_req) check("inst_addr", mem_bus.inst_addr, m_pc);
            check("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
            if (m_valid) begin
                check("if_pc", if_pc, m_ifpc);
                check("if_inst", if_inst, m_ifinst);
            end
        end
    end

    // Stimulus knobs, applied on the falling edge by step()
    int          ao_pct = 100;
    int          do_pct = 100;
    bit          ao_off = 1'b0;
    bit          do_off = 1'b0;
    bit          do_on  = 1'b0;
    bit          nx_rst = 1'b1;
    bit          nx_br  = 1'b0;
    bit          nx_jp  = 1'b0;
    bit          nx_idr = 1'b1;
    logic [31:0] nx_ba  = 32'd0;
    logic [31:0] nx_ja  = 32'd0;

    task automatic step();
        @(negedge clk);
        rst         = nx_rst;
        branch_en   = nx_br;
        branch_addr = nx_ba;
        jump_en     = nx_jp;
        jump_addr   = nx_ja;
        id_ready    = nx_idr;
        mem_bus.inst_addr_ok = ao_off ? 1'b0 : (int'($urandom_range(0, 99)) < ao_pct);
        mem_bus.inst_data_ok = do_on ? 1'b1 : do_off ? 1'b0 : (int'($urandom_range(0, 99)) < do_pct);
        mem_bus.inst_rdata   = m_fly ? memword(m_fly_addr) : $urandom;
    endtask

    task automatic step_until_valid(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (if_valid) return;
        end
        n_checks++; n_errors++;
        $display("FAIL timeout %s: got no if_valid expected one within %0d cycles", name, budget);
    endtask

    task automatic step_until_req(input string name, input int budget);
        if (mem_bus.inst_req) return;
        for (int i = 0; i < budget; i++) begin
            step();
            if (mem_bus.inst_req) return;
        end
        n_checks++; n_errors++;
        $display("FAIL timeout %s: got no inst_req expected one within %0d cycles", name, budget);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got no finish expected one before 1000000");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] got [3];
        logic [31:0] rec_pc, rec_inst;
        int          ngot;

        rst = 1'b1; branch_en = 1'b0; branch_addr = 32'd0; jump_en = 1'b0;
        jump_addr = 32'd0; id_ready = 1'b1;
        mem_bus.inst_addr_ok = 1'b0; mem_bus.inst_data_ok = 1'b0; mem_bus.inst_rdata = 32'd0;

        step();
        chk_en = 1'b1;
        step();
        check("rst_inst_req", {31'd0, mem_bus.inst_req}, 32'd0);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_if_pc", if_pc, 32'd0);
        check("rst_if_inst", if_inst, 32'd0);
        check("rst_pc", mem_bus.inst_addr, RST_PC);

        // First request in the second cycle after reset release
        nx_rst = 1'b0;
        step();
        check("first_cycle_req", {31'd0, mem_bus.inst_req}, 32'd0);
        step();
        check("second_cycle_req", {31'd0, mem_bus.inst_req}, 32'd1);
        check("second_cycle_addr", mem_bus.inst_addr, RST_PC);

        // Zero-wait memory, ID always ready: sequential PCs
        ngot = 0;
        got[0] = 32'd0; got[1] = 32'd0; got[2] = 32'd0;
        for (int i = 0; i < 30 && ngot < 3; i++) begin
            if (if_valid) begin
                got[ngot] = if_pc;
                check("seq_inst", if_inst, memword(if_pc));
                ngot++;
            end
            if (ngot < 3) step();
        end
        check("seq_pc0", got[0], 32'h1C000000);
        check("seq_pc1", got[1], 32'h1C000004);
        check("seq_pc2", got[2], 32'h1C000008);

        // ID stall: held instruction stays put, no new request
        nx_idr = 1'b0;
        step_until_valid("stall", 20);
        rec_pc = if_pc; rec_inst = if_inst;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid", {31'd0, if_valid}, 32'd1);
            check("stall_pc", if_pc, rec_pc);
            check("stall_inst", if_inst, rec_inst);
            check("stall_req", {31'd0, mem_bus.inst_req}, 32'd0);
        end
        nx_idr = 1'b1;
        step();
        step();
        check("unstall_valid", {31'd0, if_valid}, 32'd0);
        check("unstall_req", {31'd0, mem_bus.inst_req}, 32'd1);
        check("unstall_addr", mem_bus.inst_addr, rec_pc + 32'd4);

        // Branch while waiting for data: word dropped, target low bits cleared
        do_off = 1'b1;
        step_until_req("br_wait", 20);
        step();
        nx_br = 1'b1; nx_ba = 32'h1C000103;
        step();
        nx_br = 1'b0; do_off = 1'b0;
        step();
        check("br_drop_valid", {31'd0, if_valid}, 32'd0);
        step();
        check("br_next_valid", {31'd0, if_valid}, 32'd0);
        check("br_next_req", {31'd0, mem_bus.inst_req}, 32'd1);
        check("br_next_addr", mem_bus.inst_addr, 32'h1C000100);

        // Jump and branch together while holding: jump wins, flush
        nx_idr = 1'b0;
        step_until_valid("flush", 20);
        nx_jp = 1'b1; nx_ja = 32'h1C000200; nx_br = 1'b1; nx_ba = 32'h1C000300; nx_idr = 1'b1;
        step();
        nx_jp = 1'b0; nx_br = 1'b0;
        step();
        check("flush_valid", {31'd0, if_valid}, 32'd0);
        check("flush_req", {31'd0, mem_bus.inst_req}, 32'd1);
        check("flush_addr", mem_bus.inst_addr, 32'h1C000200);

        // PC wrap at the top of the address space
        nx_jp = 1'b1; nx_ja = 32'hFFFFFFFF;
        step();
        nx_jp = 1'b0;
        step_until_req("wrap_req", 20);
        check("wrap_first_addr", mem_bus.inst_addr, 32'hFFFFFFFC);
        step_until_valid("wrap_fetch", 20);
        check("wrap_if_pc", if_pc, 32'hFFFFFFFC);
        step_until_req("wrap_next", 20);
        check("wrap_next_addr", mem_bus.inst_addr, 32'h00000000);

        // Reset while waiting, then a stale data_ok arrives
        do_off = 1'b1;
        step_until_req("rst_wait", 20);
        step();
        nx_rst = 1'b1;
        step();
        nx_rst = 1'b0; do_off = 1'b0; do_on = 1'b1; ao_off = 1'b1;
        step();
        check("late_idle_req", {31'd0, mem_bus.inst_req}, 32'd0);
        check("late_idle_valid", {31'd0, if_valid}, 32'd0);
        step();
        check("late_req", {31'd0, mem_bus.inst_req}, 32'd1);
        check("late_addr", mem_bus.inst_addr, RST_PC);
        check("late_valid", {31'd0, if_valid}, 32'd0);
        step();
        check("late_valid2", {31'd0, if_valid}, 32'd0);
        do_on = 1'b0; ao_off = 1'b0;

        // Randomized traffic checked every cycle by the compare process
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) begin
                ao_pct = int'($urandom_range(20, 100));
                do_pct = int'($urandom_range(20, 100));
            end
            nx_idr = ($urandom_range(0, 99) < 60);
            nx_br  = ($urandom_range(0, 99) < 4);
            nx_jp  = ($urandom_range(0, 99) < 3);
            nx_ba  = $urandom;
            nx_ja  = $urandom;
            nx_rst = ($urandom_range(0, 999) < 3);
            step();
        end
        nx_br = 1'b0; nx_jp = 1'b0; nx_rst = 1'b0; nx_idr = 1'b1;
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
